// File: rtl/led_afterglow.sv
// Per-lane afterglow dimmer: a lit pattern bit drives its LED fully on, and a
// cleared bit fades linearly to off through PWM duty steps paced by a prescaler.
module led_afterglow #(
    parameter int N_LED     = 16,
    parameter int BW        = 4,
    parameter int DECAY_DIV = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_LED-1:0] led_in,
    input  logic             led_in_valid,
    input  logic             en,
    output logic [N_LED-1:0] led_out,
    output logic             glow_active
);

    localparam int PW = $clog2(DECAY_DIV);
    localparam logic [BW-1:0] LVL_MAX  = {BW{1'b1}};
    localparam logic [BW-1:0] LVL_ZERO = {BW{1'b0}};
    localparam logic [BW-1:0] LVL_ONE  = BW'(1'b1);
    localparam logic [PW-1:0] PRE_LAST = PW'(DECAY_DIV - 1);
    localparam logic [PW-1:0] PRE_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] PRE_ONE  = PW'(1'b1);

    logic [BW-1:0]             pwm_cnt_r;
    logic [PW-1:0]             pre_cnt_r;
    logic [N_LED-1:0][BW-1:0]  lvl_r;
    logic [N_LED-1:0][BW-1:0]  lvl_nxt_s;
    logic [N_LED-1:0]          led_nxt_s;
    logic                      decay_tick_s;

    assign decay_tick_s = (pre_cnt_r == PRE_LAST);

    // PWM phase counter; wraps naturally from MAX to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_cnt_r <= LVL_ZERO;
        end else begin
            pwm_cnt_r <= pwm_cnt_r + LVL_ONE;
        end
    end

    // Decay prescaler, one decay_tick every DECAY_DIV cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_cnt_r <= PRE_ZERO;
        end else if (decay_tick_s) begin
            pre_cnt_r <= PRE_ZERO;
        end else begin
            pre_cnt_r <= pre_cnt_r + PRE_ONE;
        end
    end

    // Next lane levels (load beats decay, decay saturates at zero) and PWM compare.
    always_comb begin
        lvl_nxt_s = lvl_r;
        led_nxt_s = {N_LED{1'b0}};
        for (int i = 0; i < N_LED; i++) begin
            if (led_in_valid && led_in[i]) begin
                lvl_nxt_s[i] = LVL_MAX;
            end else if (decay_tick_s && (lvl_r[i] != LVL_ZERO)) begin
                lvl_nxt_s[i] = lvl_r[i] - LVL_ONE;
            end else begin
                lvl_nxt_s[i] = lvl_r[i];
            end
            led_nxt_s[i] = en & ((lvl_r[i] == LVL_MAX) | (lvl_r[i] > pwm_cnt_r));
        end
    end

    // Lane level registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lvl_r <= {(N_LED*BW){1'b0}};
        end else begin
            lvl_r <= lvl_nxt_s;
        end
    end

    // Registered LED drive; gating with en only hides the fade, it does not stop it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_out <= {N_LED{1'b0}};
        end else begin
            led_out <= led_nxt_s;
        end
    end

    assign glow_active = |lvl_r;

endmodule

// File: tb/tb_led_afterglow.sv
// Randomised and directed bench for led_afterglow, checked every cycle against
// an integer reference model of the lane levels, PWM phase and prescaler.
module tb_led_afterglow;

    localparam int N    = 16;
    localparam int BW   = 4;
    localparam int DD   = 64;
    localparam int MAXL = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  led_in = 16'h0000;
    logic          led_in_valid = 1'b0;
    logic          en = 1'b1;
    logic [N-1:0]  led_out;
    logic          glow_active;

    int checks = 0;
    int errors = 0;

    int           m_lvl [N];
    int           m_pwm;
    int           m_pre;
    logic [N-1:0] m_led;

    led_afterglow #(.N_LED(N), .BW(BW), .DECAY_DIV(DD)) dut (
        .clk          (clk),
        .rst          (rst),
        .led_in       (led_in),
        .led_in_valid (led_in_valid),
        .en           (en),
        .led_out      (led_out),
        .glow_active  (glow_active)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic m_glow();
        for (int i = 0; i < N; i++) begin
            if (m_lvl[i] != 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_pwm = 0;
        m_pre = 0;
        m_led = 16'h0000;
        for (int i = 0; i < N; i++) m_lvl[i] = 0;
    endtask

    // One clock edge: advance the model with the pre-edge inputs, then compare.
    task automatic step();
        bit tick;
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            tick = (m_pre == DD - 1);
            for (int i = 0; i < N; i++)
                m_led[i] = en && ((m_lvl[i] == MAXL) || (m_lvl[i] > m_pwm));
            for (int i = 0; i < N; i++) begin
                if (led_in_valid && led_in[i]) m_lvl[i] = MAXL;
                else if (tick && m_lvl[i] > 0) m_lvl[i] = m_lvl[i] - 1;
            end
            m_pwm = (m_pwm + 1) % (1 << BW);
            m_pre = (m_pre + 1) % DD;
        end
        #1;
        check_val("led_out", 32'(led_out), 32'(m_led));
        check_val("glow_active", 32'(glow_active), 32'(m_glow()));
    endtask

    task automatic pulse(input logic [N-1:0] v);
        led_in       = v;
        led_in_valid = 1'b1;
        step();
        led_in_valid = 1'b0;
        led_in       = 16'h0000;
    endtask

    task automatic run_until_pre(input int v);
        for (int k = 0; k < DD + 1; k++) begin
            if (m_pre == v) break;
            step();
        end
        check_val("pre_reach", 32'(m_pre), 32'(v));
    endtask

    initial begin
        int cnt [16];
        int lvc [16];
        int lv, ticks, fall_tick, hi;

        model_reset();

        // Reset hold, then idle with no strobes.
        rst = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        repeat (200) step();
        check_val("idle_led", 32'(led_out), 32'h0000);
        check_val("idle_glow", 32'(glow_active), 32'h0);

        // Full on: visible one edge after the strobe.
        pulse(16'h0001);
        check_val("load_latency", 32'(led_out), 32'h0000);
        step();
        check_val("full_on", 32'(led_out), 32'h0001);

        // Fade: per-level high counts over each decay interval.
        for (int i = 0; i < 16; i++) begin cnt[i] = 0; lvc[i] = 0; end
        ticks = 0;
        fall_tick = -1;
        for (int k = 0; k < 1200; k++) begin
            lv = m_lvl[0];
            if (m_pre == DD - 1) ticks++;
            step();
            lvc[lv]++;
            if (led_out[0]) cnt[lv]++;
            if (fall_tick < 0 && glow_active == 1'b0) fall_tick = ticks;
        end
        for (int l = 1; l < MAXL; l++) begin
            check_val($sformatf("fade_hi_l%0d", l), 32'(cnt[l]), 32'(4 * l));
            check_val($sformatf("fade_len_l%0d", l), 32'(lvc[l]), 32'(DD));
        end
        check_val("fade_hi_l0", 32'(cnt[0]), 32'h0);
        check_val("glow_fall_tick", 32'(fall_tick), 32'd15);

        // Collision: load on the decay_tick edge wins over the decrement.
        pulse(16'hFFFF);
        run_until_pre(DD - 1);
        step();
        run_until_pre(DD - 1);
        pulse(16'h8001);
        hi = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            if (led_out[1]) hi++;
            check_val("collision_full", 32'(led_out & 16'h8001), 32'h8001);
        end
        check_val("collision_decay_duty", 32'(hi), 32'd13);

        // Enable gating: hide lane 3 at level 9, resume at level 7.
        pulse(16'h0008);
        for (int k = 0; k < 600; k++) begin
            if (m_lvl[3] == 9) break;
            step();
        end
        check_val("lvl3_reach", 32'(m_lvl[3]), 32'd9);
        en = 1'b0;
        step();
        check_val("en_gate_led", 32'(led_out), 32'h0000);
        check_val("en_gate_glow", 32'(glow_active), 32'h1);
        run_until_pre(DD - 1);
        step();
        run_until_pre(DD - 1);
        step();
        check_val("en_gate_led2", 32'(led_out), 32'h0000);
        en = 1'b1;
        hi = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            if (led_out[3]) hi++;
        end
        check_val("en_resume_duty", 32'(hi), 32'd7);

        // Asynchronous reset between edges while lanes are lit.
        pulse(16'hFFFF);
        repeat (3) step();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("async_rst_led", 32'(led_out), 32'h0000);
        check_val("async_rst_glow", 32'(glow_active), 32'h0);
        model_reset();
        repeat (2) step();
        rst = 1'b1;
        pulse(16'h0001);
        repeat (150) step();

        // Randomised traffic with occasional enable changes.
        for (int k = 0; k < 3000; k++) begin
            led_in       = 16'($urandom);
            led_in_valid = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 49) == 0) en = ~en;
            step();
        end
        led_in_valid = 1'b0;
        en = 1'b1;
        repeat (20) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
